// File: rtl/cross_bar_pkg.sv
// Shared cross bar types and constants, plus the per-slave arbiter state encoding.
package cross_bar_pkg;

    localparam int MASTER_N = 4;
    localparam int SLAVE_N  = 4;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/cross_bar_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after ptr.
module cross_bar_rr_pick #(
    parameter int REQ_N = 4,
    parameter int PTR_W = 2
) (
    input  logic [REQ_N-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [REQ_N-1:0] gnt,
    output logic             valid
);

    logic found_s;

    // Walk the requesters starting at ptr, wrapping, and keep only the first hit.
    always_comb begin
        int idx;
        logic take;
        gnt     = '0;
        found_s = 1'b0;
        for (int off = 0; off < REQ_N; off++) begin
            idx      = (int'(ptr) + off) % REQ_N;
            take     = req[idx] & ~found_s;
            gnt[idx] = take;
            found_s  = found_s | take;
        end
        valid = |req;
    end

endmodule

// File: rtl/cross_bar_slave_arb.sv
// Per-slave round-robin arbiter/sequencer; holds the grant from request to ack.
// Optional forced termination of stuck transactions with macro CROSS_BAR_ARB_TIMEOUT_EN.
module cross_bar_slave_arb
    import cross_bar_pkg::*;
#(
    parameter int    REQ_N       = MASTER_N,
    parameter int    TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT,
    parameter data_t TO_RDATA    = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REQ_N-1:0] m_req,
    input  addr_t            m_addr  [REQ_N],
    input  logic [REQ_N-1:0] m_cmd,
    input  data_t            m_wdata [REQ_N],
    output logic [REQ_N-1:0] m_ack,
    output data_t            m_rdata,
    output logic             s_req,
    output addr_t            s_addr,
    output logic             s_cmd,
    output data_t            s_wdata,
    input  logic             s_ack,
    input  data_t            s_rdata,
    output logic [REQ_N-1:0] grant,
    output logic             timeout_err
);

    localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

    arb_state_t       state_r;
    logic [REQ_N-1:0] grant_r;
    logic [PTR_W-1:0] ptr_r;
    logic [REQ_N-1:0] pick_gnt_s;
    logic             pick_valid_s;
    logic [PTR_W-1:0] gnt_idx_s;
    logic [PTR_W-1:0] next_ptr_s;
    logic             busy_s;
    logic             req_held_s;
    logic             ack_s;
    logic             to_fire_s;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [REQ_N-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < REQ_N; i++) begin
            idx = idx | (oh[i] ? PTR_W'(i) : {PTR_W{1'b0}});
        end
        return idx;
    endfunction

    cross_bar_rr_pick #(
        .REQ_N (REQ_N),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (m_req),
        .ptr   (ptr_r),
        .gnt   (pick_gnt_s),
        .valid (pick_valid_s)
    );

    assign busy_s     = (state_r == BUSY);
    assign req_held_s = |(m_req & grant_r);
    assign ack_s      = busy_s & s_ack;
    assign gnt_idx_s  = onehot_to_idx(grant_r);
    assign next_ptr_s = (gnt_idx_s == PTR_W'(REQ_N - 1)) ? {PTR_W{1'b0}} : gnt_idx_s + PTR_W'(1);
    assign grant      = grant_r;

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_r;

    // A real slave ack in the same cycle always beats the timeout.
    assign to_fire_s = busy_s & req_held_s & ~s_ack & (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign to_fire_s = 1'b0;
`endif

    // Slave-side muxing and ack/rdata return, driven from the registered grant.
    always_comb begin
        s_req       = busy_s & req_held_s & ~to_fire_s;
        timeout_err = to_fire_s;
        if (busy_s) begin
            s_addr  = m_addr[gnt_idx_s];
            s_cmd   = m_cmd[gnt_idx_s];
            s_wdata = m_wdata[gnt_idx_s];
        end else begin
            s_addr  = '0;
            s_cmd   = 1'b0;
            s_wdata = '0;
        end
        if (ack_s) begin
            m_ack   = grant_r;
            m_rdata = s_rdata;
        end else if (to_fire_s) begin
            m_ack   = grant_r;
            m_rdata = TO_RDATA;
        end else begin
            m_ack   = '0;
            m_rdata = '0;
        end
    end

    // Arbitration FSM with round-robin pointer and optional BUSY cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            grant_r <= '0;
            ptr_r   <= '0;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
            cnt_r   <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant_r <= pick_gnt_s;
                        state_r <= BUSY;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
                        cnt_r   <= '0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    // Dropped request also advances ptr so the quitter cannot hog the slot.
                    if (ack_s || !req_held_s || to_fire_s) begin
                        state_r <= IDLE;
                        grant_r <= '0;
                        ptr_r   <= next_ptr_s;
                    end else begin
                        state_r <= BUSY;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
                        cnt_r   <= cnt_r + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cross_bar_slave_arb.sv
// Table-driven bench for cross_bar_slave_arb plus hand sequences for reset and timeout.
module tb_cross_bar_slave_arb;
    import cross_bar_pkg::*;

    localparam int    N     = 4;
    localparam data_t TO_RD = 32'hFFFF_FFFF;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   m_req;
    addr_t          m_addr  [N];
    logic [N-1:0]   m_cmd;
    data_t          m_wdata [N];
    logic [N-1:0]   m_ack;
    data_t          m_rdata;
    logic           s_req;
    addr_t          s_addr;
    logic           s_cmd;
    data_t          s_wdata;
    logic           s_ack;
    data_t          s_rdata;
    logic [N-1:0]   grant;
    logic           timeout_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  cmd;
        logic        ack;
        logic [31:0] rdata;
        logic [3:0]  g;
        logic        sreq;
        logic [3:0]  mack;
        logic [31:0] mrd;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    cross_bar_slave_arb #(
        .REQ_N       (N),
        .TIMEOUT_CYC (8),
        .TO_RDATA    (TO_RD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_req       (m_req),
        .m_addr      (m_addr),
        .m_cmd       (m_cmd),
        .m_wdata     (m_wdata),
        .m_ack       (m_ack),
        .m_rdata     (m_rdata),
        .s_req       (s_req),
        .s_addr      (s_addr),
        .s_cmd       (s_cmd),
        .s_wdata     (s_wdata),
        .s_ack       (s_ack),
        .s_rdata     (s_rdata),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic sreq,
                              input logic [3:0] mack, input logic [31:0] mrd,
                              input logic terr, input logic [3:0] cmd);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".s_req"}, 32'(s_req), 32'(sreq));
        chk({tag, ".m_ack"}, 32'(m_ack), 32'(mack));
        chk({tag, ".m_rdata"}, m_rdata, mrd);
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(terr));
        if (g != 4'h0) begin
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    chk({tag, ".s_addr"}, s_addr, 32'h10 + 32'(i) * 32'd16);
                    chk({tag, ".s_wdata"}, s_wdata, 32'hA5 + 32'(i));
                    chk({tag, ".s_cmd"}, 32'(s_cmd), 32'(cmd[i]));
                end
            end
        end
    endtask

    initial begin
        int nto;
        // req, cmd, s_ack, s_rdata, exp grant, exp s_req, exp m_ack, exp m_rdata
        tbl[0]  = '{4'hF, 4'h0, 1'b1, 32'hDEAD_BEEF, 4'h0, 1'b0, 4'h0, 32'h0};
        tbl[1]  = '{4'hF, 4'h0, 1'b1, 32'h11, 4'h1, 1'b1, 4'h1, 32'h11};
        tbl[2]  = '{4'hF, 4'h0, 1'b0, 32'h0,  4'h0, 1'b0, 4'h0, 32'h0};
        tbl[3]  = '{4'hF, 4'h0, 1'b1, 32'h22, 4'h2, 1'b1, 4'h2, 32'h22};
        tbl[4]  = '{4'hF, 4'h0, 1'b0, 32'h0,  4'h0, 1'b0, 4'h0, 32'h0};
        tbl[5]  = '{4'hF, 4'h0, 1'b1, 32'h33, 4'h4, 1'b1, 4'h4, 32'h33};
        tbl[6]  = '{4'hF, 4'h0, 1'b0, 32'h0,  4'h0, 1'b0, 4'h0, 32'h0};
        tbl[7]  = '{4'hF, 4'h0, 1'b1, 32'h44, 4'h8, 1'b1, 4'h8, 32'h44};
        tbl[8]  = '{4'hF, 4'h0, 1'b0, 32'h0,  4'h0, 1'b0, 4'h0, 32'h0};
        tbl[9]  = '{4'hF, 4'h0, 1'b1, 32'h55, 4'h1, 1'b1, 4'h1, 32'h55};
        tbl[10] = '{4'h0, 4'h0, 1'b0, 32'h0,  4'h0, 1'b0, 4'h0, 32'h0};
        tbl[11] = '{4'h2, 4'h0, 1'b0, 32'h0,  4'h0, 1'b0, 4'h0, 32'h0};
        tbl[12] = '{4'h2, 4'h0, 1'b1, 32'h1234_5678, 4'h2, 1'b1, 4'h2, 32'h1234_5678};
        tbl[13] = '{4'h9, 4'h0, 1'b0, 32'h0,  4'h0, 1'b0, 4'h0, 32'h0};
        tbl[14] = '{4'h9, 4'h0, 1'b1, 32'h66, 4'h8, 1'b1, 4'h8, 32'h66};
        tbl[15] = '{4'h1, 4'h1, 1'b0, 32'h0,  4'h0, 1'b0, 4'h0, 32'h0};
        tbl[16] = '{4'h1, 4'h1, 1'b0, 32'h0,  4'h1, 1'b1, 4'h0, 32'h0};
        tbl[17] = '{4'h1, 4'h1, 1'b0, 32'h0,  4'h1, 1'b1, 4'h0, 32'h0};
        tbl[18] = '{4'h1, 4'h1, 1'b1, 32'h0,  4'h1, 1'b1, 4'h1, 32'h0};
        tbl[19] = '{4'h4, 4'h0, 1'b0, 32'h0,  4'h0, 1'b0, 4'h0, 32'h0};
        tbl[20] = '{4'h4, 4'h0, 1'b0, 32'h0,  4'h4, 1'b1, 4'h0, 32'h0};
        tbl[21] = '{4'h0, 4'h0, 1'b0, 32'h0,  4'h4, 1'b0, 4'h0, 32'h0};
        tbl[22] = '{4'hF, 4'h0, 1'b0, 32'h0,  4'h0, 1'b0, 4'h0, 32'h0};
        tbl[23] = '{4'hF, 4'h0, 1'b0, 32'h0,  4'h8, 1'b1, 4'h0, 32'h0};
        tbl[24] = '{4'hF, 4'h0, 1'b0, 32'h0,  4'h8, 1'b1, 4'h0, 32'h0};

        for (int i = 0; i < N; i++) begin
            m_addr[i]  = 32'h10 + 32'(i) * 32'd16;
            m_wdata[i] = 32'hA5 + 32'(i);
        end
        reset   = 1'b1;
        m_req   = 4'h0;
        m_cmd   = 4'h0;
        s_ack   = 1'b0;
        s_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset   = 1'b0;
            m_req   = tbl[i].req;
            m_cmd   = tbl[i].cmd;
            s_ack   = tbl[i].ack;
            s_rdata = tbl[i].rdata;
            #1;
            check_outs($sformatf("row%0d", i), tbl[i].g, tbl[i].sreq, tbl[i].mack,
                       tbl[i].mrd, 1'b0, tbl[i].cmd);
        end

        // Reset in the middle of m3's transaction; a stale ack afterwards must be ignored.
        @(negedge clk);
        reset = 1'b1;
        s_ack = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        m_req   = 4'hF;
        m_cmd   = 4'h0;
        s_ack   = 1'b1;
        s_rdata = 32'hBAD0_BAD0;
        #1;
        check_outs("midrst", 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
        @(negedge clk);
        s_ack = 1'b0;
        #1;
        check_outs("midrst_ptr0", 4'h1, 1'b1, 4'h0, 32'h0, 1'b0, 4'h0);

        // Slave never answers a single request from m0.
        @(negedge clk);
        reset = 1'b1;
        m_req = 4'h0;
        @(negedge clk);
        reset   = 1'b0;
        m_req   = 4'h1;
        s_rdata = 32'h0;
        #1;
        check_outs("to_idle", 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
        nto = 8;
`else
        nto = 12;
`endif
        for (int k = 1; k <= nto; k++) begin
            @(negedge clk);
            #1;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
            if (k == 8) begin
                check_outs($sformatf("to_busy%0d", k), 4'h1, 1'b0, 4'h1, TO_RD, 1'b1, 4'h0);
            end else begin
                check_outs($sformatf("to_busy%0d", k), 4'h1, 1'b1, 4'h0, 32'h0, 1'b0, 4'h0);
            end
`else
            check_outs($sformatf("wait_busy%0d", k), 4'h1, 1'b1, 4'h0, 32'h0, 1'b0, 4'h0);
`endif
        end
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
        @(negedge clk);
        #1;
        check_outs("to_after", 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
